// File: rtl/axi_trace_logger.sv
// Snoops one AXI address channel and records each accepted beat as {addr[hi:LEN_WIDTH], len}
// in a trace RAM that is read back through a one-cycle-latency, read-first port.
module axi_trace_logger #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int DEPTH      = 256,
    parameter int WRAP       = 0,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  mon_valid,
    input  logic                  mon_ready,
    input  logic [ADDR_WIDTH-1:0] mon_addr,
    input  logic [LEN_WIDTH-1:0]  mon_len,
    input  logic                  clear,
    input  logic                  rd_req,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_data,
    output logic [IDX_WIDTH:0]    count,
    output logic [IDX_WIDTH-1:0]  wr_ptr,
    output logic                  overflow
);

    localparam logic [IDX_WIDTH:0] FULL_COUNT = (IDX_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];

    logic [IDX_WIDTH:0]    count_q, count_d;
    logic [IDX_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_valid_q;
    logic [ADDR_WIDTH-1:0] rd_data_q;

    logic                  capture;
    logic                  full;
    logic                  do_write;
    logic                  rd_hit;
    logic [ADDR_WIDTH-1:0] entry;

    assign capture  = mon_valid & mon_ready;
    assign full     = (count_q == FULL_COUNT);
    // clear wins over a same-cycle capture; a full stop-mode trace drops the beat.
    assign do_write = capture & ~clear & (~full | (WRAP != 0));
    assign entry    = {mon_addr[ADDR_WIDTH-1:LEN_WIDTH], mon_len};
    assign rd_hit   = ({1'b0, rd_idx} < count_q);

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        if (clear) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
        end else if (capture) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + (IDX_WIDTH + 1)'(1);
            end
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + IDX_WIDTH'(1);
            end
        end
    end

    // NOTE: the trace RAM has no reset; count gates every read, so stale words never reach rd_data.
    always_ff @(posedge Clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= entry;
        end
    end

    // NOTE: non-blocking reads of mem give read-first behaviour on a same-index collision.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_hit ? mem[rd_idx] : '0;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign wr_ptr   = wr_ptr_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_axi_trace_logger.sv
// Directed bench: one deep stop-mode logger and two 4-deep loggers (stop and circular)
// driven by the same snooped channel, with hand-computed expectations per scenario.
module tb_axi_trace_logger;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        mon_valid = 1'b0;
    logic        mon_ready = 1'b0;
    logic [31:0] mon_addr = '0;
    logic [3:0]  mon_len = '0;
    logic        clear = 1'b0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_idx = '0;

    logic        big_rd_valid, stp_rd_valid, wrp_rd_valid;
    logic [31:0] big_rd_data, stp_rd_data, wrp_rd_data;
    logic [8:0]  big_count;
    logic [2:0]  stp_count, wrp_count;
    logic [7:0]  big_wr_ptr;
    logic [1:0]  stp_wr_ptr, wrp_wr_ptr;
    logic        big_overflow, stp_overflow, wrp_overflow;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    axi_trace_logger #(.DEPTH(256), .WRAP(0)) u_big (
        .Clk(Clk), .Rst_n(Rst_n), .mon_valid(mon_valid), .mon_ready(mon_ready),
        .mon_addr(mon_addr), .mon_len(mon_len), .clear(clear), .rd_req(rd_req),
        .rd_idx(rd_idx), .rd_valid(big_rd_valid), .rd_data(big_rd_data),
        .count(big_count), .wr_ptr(big_wr_ptr), .overflow(big_overflow));

    axi_trace_logger #(.DEPTH(4), .WRAP(0)) u_stp (
        .Clk(Clk), .Rst_n(Rst_n), .mon_valid(mon_valid), .mon_ready(mon_ready),
        .mon_addr(mon_addr), .mon_len(mon_len), .clear(clear), .rd_req(rd_req),
        .rd_idx(rd_idx[1:0]), .rd_valid(stp_rd_valid), .rd_data(stp_rd_data),
        .count(stp_count), .wr_ptr(stp_wr_ptr), .overflow(stp_overflow));

    axi_trace_logger #(.DEPTH(4), .WRAP(1)) u_wrp (
        .Clk(Clk), .Rst_n(Rst_n), .mon_valid(mon_valid), .mon_ready(mon_ready),
        .mon_addr(mon_addr), .mon_len(mon_len), .clear(clear), .rd_req(rd_req),
        .rd_idx(rd_idx[1:0]), .rd_valid(wrp_rd_valid), .rd_data(wrp_rd_data),
        .count(wrp_count), .wr_ptr(wrp_wr_ptr), .overflow(wrp_overflow));

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] addr, input logic [3:0] len);
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_addr  = addr;
        mon_len   = len;
        cyc();
        mon_valid = 1'b0;
        mon_ready = 1'b0;
    endtask

    task automatic read(input logic [7:0] idx);
        rd_req = 1'b1;
        rd_idx = idx;
        cyc();
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        #12;
        checks++;
        if ({big_rd_valid, big_rd_data, big_count, big_wr_ptr, big_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_big: got valid=%b data=%h count=%0d ptr=%0d ovf=%b, want all 0",
                     big_rd_valid, big_rd_data, big_count, big_wr_ptr, big_overflow);
        end
        checks++;
        if ({stp_count, stp_wr_ptr, stp_overflow, wrp_count, wrp_wr_ptr, wrp_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_small: got stp count=%0d ptr=%0d ovf=%b wrp count=%0d ptr=%0d ovf=%b, want 0",
                     stp_count, stp_wr_ptr, stp_overflow, wrp_count, wrp_wr_ptr, wrp_overflow);
        end
        cyc();
        Rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_capture();
        capture(32'h0000_0400, 4'd3);
        checks++;
        if (big_count !== 9'd1 || big_wr_ptr !== 8'd1) begin
            errors++;
            $display("FAIL single_cnt: got count=%0d ptr=%0d, want 1/1", big_count, big_wr_ptr);
        end
        read(8'd0);
        checks++;
        if (big_rd_valid !== 1'b1 || big_rd_data !== 32'h0000_0403) begin
            errors++;
            $display("FAIL single_read: got valid=%b data=%h, want 1/00000403", big_rd_valid, big_rd_data);
        end
        cyc();
        checks++;
        if (big_rd_valid !== 1'b0 || big_rd_data !== 32'h0000_0403) begin
            errors++;
            $display("FAIL single_hold: got valid=%b data=%h, want 0/00000403", big_rd_valid, big_rd_data);
        end
    endtask

    task automatic test_unwritten();
        capture(32'h0000_0500, 4'd2);
        read(8'd5);
        checks++;
        if (big_count !== 9'd2 || big_rd_valid !== 1'b1 || big_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL unwritten_read: got count=%0d valid=%b data=%h, want 2/1/0",
                     big_count, big_rd_valid, big_rd_data);
        end
        read(8'd1);
        checks++;
        if (big_rd_data !== 32'h0000_0502) begin
            errors++;
            $display("FAIL second_entry: got %h, want 00000502", big_rd_data);
        end
        mon_valid = 1'b1;
        mon_ready = 1'b0;
        mon_addr  = 32'h0000_0900;
        repeat (10) cyc();
        mon_valid = 1'b0;
        checks++;
        if (big_count !== 9'd2 || big_wr_ptr !== 8'd2) begin
            errors++;
            $display("FAIL stalled_hs: got count=%0d ptr=%0d, want 2/2", big_count, big_wr_ptr);
        end
    endtask

    task automatic test_full();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++;
        if (stp_count !== 3'd0 || wrp_count !== 3'd0 || big_count !== 9'd0) begin
            errors++;
            $display("FAIL clear: got counts %0d/%0d/%0d, want 0", stp_count, wrp_count, big_count);
        end
        for (int i = 1; i <= 5; i++) capture(32'(i * 16), 4'd0);
        checks++;
        if (stp_count !== 3'd4 || stp_overflow !== 1'b1 || stp_wr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL stop_full: got count=%0d ovf=%b ptr=%0d, want 4/1/0",
                     stp_count, stp_overflow, stp_wr_ptr);
        end
        checks++;
        if (wrp_count !== 3'd4 || wrp_overflow !== 1'b1 || wrp_wr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL wrap_full: got count=%0d ovf=%b ptr=%0d, want 4/1/1",
                     wrp_count, wrp_overflow, wrp_wr_ptr);
        end
        checks++;
        if (big_count !== 9'd5 || big_overflow !== 1'b0) begin
            errors++;
            $display("FAIL big_notfull: got count=%0d ovf=%b, want 5/0", big_count, big_overflow);
        end
        read(8'd0);
        checks++;
        if (stp_rd_data !== 32'h10 || wrp_rd_data !== 32'h50) begin
            errors++;
            $display("FAIL full_idx0: got stop=%h wrap=%h, want 10/50", stp_rd_data, wrp_rd_data);
        end
        read(8'd1);
        checks++;
        if (wrp_rd_data !== 32'h20) begin
            errors++;
            $display("FAIL wrap_idx1: got %h, want 00000020", wrp_rd_data);
        end
        read(8'd3);
        checks++;
        if (stp_rd_data !== 32'h40) begin
            errors++;
            $display("FAIL stop_idx3: got %h, want 00000040", stp_rd_data);
        end
    endtask

    task automatic test_clear_collision();
        clear     = 1'b1;
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_addr  = 32'h0000_0600;
        cyc();
        clear     = 1'b0;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        checks++;
        if ({big_count, big_wr_ptr, big_overflow, stp_count, stp_wr_ptr, stp_overflow,
             wrp_count, wrp_wr_ptr, wrp_overflow} !== '0) begin
            errors++;
            $display("FAIL clear_cap: got big %0d/%0d/%b stop %0d/%0d/%b wrap %0d/%0d/%b, want 0",
                     big_count, big_wr_ptr, big_overflow, stp_count, stp_wr_ptr, stp_overflow,
                     wrp_count, wrp_wr_ptr, wrp_overflow);
        end
        read(8'd0);
        checks++;
        if (big_rd_data !== 32'h0 || stp_rd_data !== 32'h0 || wrp_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL clear_stale: got %h/%h/%h, want 0", big_rd_data, stp_rd_data, wrp_rd_data);
        end
    endtask

    task automatic test_collision();
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_addr  = 32'h0000_0700;
        mon_len   = 4'd0;
        rd_req    = 1'b1;
        rd_idx    = 8'd0;
        cyc();
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        rd_req    = 1'b0;
        checks++;
        if (big_rd_data !== 32'h0 || big_count !== 9'd1) begin
            errors++;
            $display("FAIL coll_empty: got data=%h count=%0d, want 0/1", big_rd_data, big_count);
        end
        for (int i = 1; i <= 3; i++) capture(32'h700 + 32'(i * 16), 4'd0);
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_addr  = 32'h0000_0740;
        rd_req    = 1'b1;
        rd_idx    = 8'd0;
        cyc();
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        rd_req    = 1'b0;
        checks++;
        if (wrp_rd_data !== 32'h700 || stp_rd_data !== 32'h700) begin
            errors++;
            $display("FAIL coll_readfirst: got wrap=%h stop=%h, want 700/700", wrp_rd_data, stp_rd_data);
        end
        read(8'd0);
        checks++;
        if (wrp_rd_data !== 32'h740 || stp_rd_data !== 32'h700) begin
            errors++;
            $display("FAIL coll_after: got wrap=%h stop=%h, want 740/700", wrp_rd_data, stp_rd_data);
        end
        read(8'd4);
        checks++;
        if (big_rd_data !== 32'h740) begin
            errors++;
            $display("FAIL big_idx4: got %h, want 00000740", big_rd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [3] = '{32'h700, 32'h710, 32'h720};
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_idx = 8'(i);
            cyc();
            checks++;
            if (stp_rd_valid !== 1'b1 || stp_rd_data !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_read%0d: got valid=%b data=%h, want 1/%h",
                         i, stp_rd_valid, stp_rd_data, exp_q[i]);
            end
        end
        rd_req = 1'b0;
        cyc();
        checks++;
        if (stp_rd_valid !== 1'b0 || stp_rd_data !== 32'h720) begin
            errors++;
            $display("FAIL b2b_idle: got valid=%b data=%h, want 0/00000720", stp_rd_valid, stp_rd_data);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) capture(32'h0000_0A00 + 32'(i * 16), 4'd5);
        read(8'd0);
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({big_rd_valid, big_rd_data, big_count, big_wr_ptr, big_overflow,
             stp_count, stp_overflow, wrp_count, wrp_overflow} !== '0) begin
            errors++;
            $display("FAIL async_rst: got valid=%b data=%h count=%0d ptr=%0d ovf=%b stop=%0d/%b wrap=%0d/%b",
                     big_rd_valid, big_rd_data, big_count, big_wr_ptr, big_overflow,
                     stp_count, stp_overflow, wrp_count, wrp_overflow);
        end
        cyc();
        Rst_n = 1'b1;
        capture(32'h0000_0800, 4'd1);
        read(8'd0);
        checks++;
        if (big_rd_data !== 32'h0000_0801 || big_count !== 9'd1 || wrp_rd_data !== 32'h0000_0801) begin
            errors++;
            $display("FAIL post_rst: got data=%h count=%0d wrap=%h, want 00000801/1/00000801",
                     big_rd_data, big_count, wrp_rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_unwritten();
        test_full();
        test_clear_collision();
        test_collision();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
